// File: rtl/johnson_phase_decoder.sv
// Decodes a Johnson counter code into a phase index, checks that it is legal and
// advances by at most one step, locks after a run of good steps, and counts rotations.
module johnson_phase_decoder #(
   parameter int WIDTH    = 8,
   parameter int PH_W     = 4,
   parameter int LOCK_CNT = 3,
   parameter int CYC_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] q_in,
   output logic [PH_W-1:0]  phase,
   output logic             phase_vld,
   output logic             illegal,
   output logic             step_err,
   output logic             wrap,
   output logic             locked,
   output logic [CYC_W-1:0] cycle_cnt
);

   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   localparam logic [PH_W-1:0] LAST_PH  = PH_W'(2 * WIDTH - 1);
   localparam logic [3:0]      LOCK_TGT = 4'(LOCK_CNT);

   // Returns {legal, index}; index is only meaningful when legal is set.
   function automatic logic [PH_W:0] decode_code(input logic [WIDTH-1:0] code);
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] cand;
      logic [PH_W:0]    res;
      ones = '1;
      res  = '0;
      for (int k = 0; k < 2 * WIDTH; k++) begin
         if (k <= WIDTH) begin
            cand = ~(ones << k);
         end else begin
            cand = ones << (k - WIDTH);
         end
         if (code == cand) begin
            res = {1'b1, PH_W'(k)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [3:0]        good_cnt_r, good_cnt_nxt_s;
   logic              prev_vld_r, prev_vld_nxt_s;
   logic [PH_W-1:0]   phase_r, phase_nxt_s;
   logic              phase_vld_r, phase_vld_nxt_s;
   logic              illegal_r, illegal_nxt_s;
   logic              step_err_r, step_err_nxt_s;
   logic              wrap_r, wrap_nxt_s;
   logic              locked_r;
   logic [CYC_W-1:0]  cycle_cnt_r, cycle_cnt_nxt_s;
   logic [PH_W:0]     dec_s;
   logic              legal_s;
   logic [PH_W-1:0]   k_s;
   logic [PH_W-1:0]   succ_s;

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_UNLOCKED;
         good_cnt_r  <= 4'd0;
         prev_vld_r  <= 1'b0;
         phase_r     <= '0;
         phase_vld_r <= 1'b0;
         illegal_r   <= 1'b0;
         step_err_r  <= 1'b0;
         wrap_r      <= 1'b0;
         locked_r    <= 1'b0;
         cycle_cnt_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         good_cnt_r  <= good_cnt_nxt_s;
         prev_vld_r  <= prev_vld_nxt_s;
         phase_r     <= phase_nxt_s;
         phase_vld_r <= phase_vld_nxt_s;
         illegal_r   <= illegal_nxt_s;
         step_err_r  <= step_err_nxt_s;
         wrap_r      <= wrap_nxt_s;
         locked_r    <= (state_nxt_s == ST_LOCKED);
         cycle_cnt_r <= cycle_cnt_nxt_s;
      end
   end

   // Next-state logic: code classification, step check, lock FSM and rotation count.
   always_comb begin
      state_nxt_s     = state_r;
      good_cnt_nxt_s  = good_cnt_r;
      prev_vld_nxt_s  = prev_vld_r;
      phase_nxt_s     = phase_r;
      phase_vld_nxt_s = phase_vld_r;
      illegal_nxt_s   = 1'b0;
      step_err_nxt_s  = 1'b0;
      wrap_nxt_s      = 1'b0;
      cycle_cnt_nxt_s = cycle_cnt_r;
      dec_s           = decode_code(q_in);
      legal_s         = dec_s[PH_W];
      k_s             = dec_s[PH_W-1:0];
      // phase_r doubles as the step reference; it is only trusted while prev_vld_r is set
      succ_s          = (phase_r == LAST_PH) ? '0 : phase_r + {{(PH_W-1){1'b0}}, 1'b1};

      if (en) begin
         if (!legal_s) begin
            illegal_nxt_s   = 1'b1;
            phase_vld_nxt_s = 1'b0;
            prev_vld_nxt_s  = 1'b0;
            good_cnt_nxt_s  = 4'd0;
            state_nxt_s     = ST_UNLOCKED;
         end else if (!prev_vld_r) begin
            phase_nxt_s     = k_s;
            phase_vld_nxt_s = 1'b1;
            prev_vld_nxt_s  = 1'b1;
            good_cnt_nxt_s  = 4'd0;
         end else if (k_s == phase_r) begin
            phase_vld_nxt_s = 1'b1;
         end else if (k_s == succ_s) begin
            phase_nxt_s     = k_s;
            phase_vld_nxt_s = 1'b1;
            good_cnt_nxt_s  = (good_cnt_r >= LOCK_TGT) ? LOCK_TGT : good_cnt_r + 4'd1;
            if ((state_r == ST_LOCKED) && (phase_r == LAST_PH)) begin
               wrap_nxt_s      = 1'b1;
               cycle_cnt_nxt_s = cycle_cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
            end else begin
               wrap_nxt_s      = 1'b0;
            end
            case (state_r)
               ST_UNLOCKED: state_nxt_s = (good_cnt_nxt_s == LOCK_TGT) ? ST_LOCKED : ST_UNLOCKED;
               ST_LOCKED:   state_nxt_s = ST_LOCKED;
               default:     state_nxt_s = ST_UNLOCKED;
            endcase
         end else begin
            step_err_nxt_s  = 1'b1;
            phase_nxt_s     = k_s;
            phase_vld_nxt_s = 1'b1;
            good_cnt_nxt_s  = 4'd0;
            state_nxt_s     = ST_UNLOCKED;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   assign phase     = phase_r;
   assign phase_vld = phase_vld_r;
   assign illegal   = illegal_r;
   assign step_err  = step_err_r;
   assign wrap      = wrap_r;
   assign locked    = locked_r;
   assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: a vector table for the main sequences plus
// hand-written sequences for long rotation runs and asynchronous reset.
module tb_johnson_phase_decoder;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] q_in;
   logic [3:0] phase;
   logic       phase_vld;
   logic       illegal;
   logic       step_err;
   logic       wrap;
   logic       locked;
   logic [7:0] cycle_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic [7:0] q;
      logic [3:0] ph;
      logic       vld;
      logic       ill;
      logic       serr;
      logic       wrp;
      logic       lk;
      logic [7:0] cyc;
   } vec_t;

   vec_t vecs[$];

   johnson_phase_decoder #(.WIDTH(8), .PH_W(4), .LOCK_CNT(3), .CYC_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .q_in(q_in),
      .phase(phase), .phase_vld(phase_vld), .illegal(illegal), .step_err(step_err),
      .wrap(wrap), .locked(locked), .cycle_cnt(cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] code_of(input int k);
      logic [7:0] ones;
      ones = 8'hFF;
      if (k <= 8) return ~(ones << k);
      else return ones << (k - 8);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic e, input logic [7:0] q, input int ph, input logic vld,
                      input logic ill, input logic serr, input logic wrp, input logic lk,
                      input int cyc);
      vec_t v;
      v.en = e; v.q = q; v.ph = 4'(ph); v.vld = vld; v.ill = ill;
      v.serr = serr; v.wrp = wrp; v.lk = lk; v.cyc = 8'(cyc);
      vecs.push_back(v);
   endtask

   task automatic apply(input logic e, input logic [7:0] q);
      @(negedge clk);
      en   = e;
      q_in = q;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int ph, input logic vld, input logic ill,
                          input logic serr, input logic wrp, input logic lk, input int cyc);
      chk({tag, ".phase"},     32'(phase),     32'(ph));
      chk({tag, ".phase_vld"}, 32'(phase_vld), 32'(vld));
      chk({tag, ".illegal"},   32'(illegal),   32'(ill));
      chk({tag, ".step_err"},  32'(step_err),  32'(serr));
      chk({tag, ".wrap"},      32'(wrap),      32'(wrp));
      chk({tag, ".locked"},    32'(locked),    32'(lk));
      chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(cyc));
   endtask

   initial begin
      int k;
      int wraps;
      int seen_wraps;
      logic [7:0] exp_cyc;

      // 1: two full rotations from phase 0; lock on the 3rd good step, one wrap
      for (int i = 0; i < 32; i++)
         add(1'b1, code_of(i % 16), i % 16, 1'b1, 1'b0, 1'b0, (i == 16), (i >= 3), (i >= 16) ? 1 : 0);
      // 2: illegal while locked, then a fresh legal code without step error, relock
      add(1'b1, 8'b0000_0101, 15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, code_of(9),  9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, code_of(10), 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, code_of(11), 11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      add(1'b1, code_of(12), 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      for (int i = 13; i <= 15; i++)
         add(1'b1, code_of(i), i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      add(1'b1, code_of(0), 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2);
      for (int i = 1; i <= 3; i++)
         add(1'b1, code_of(i), i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      // 3: jump 3 -> 6 gives step_err, relock after three good steps
      add(1'b1, 8'b0011_1111, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
      add(1'b1, code_of(7), 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      add(1'b1, code_of(8), 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      add(1'b1, code_of(9), 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      for (int i = 10; i <= 15; i++)
         add(1'b1, code_of(i), i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      add(1'b1, code_of(0), 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);
      for (int i = 1; i <= 4; i++)
         add(1'b1, code_of(i), i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      // 4: hold phase 4 for five cycles
      for (int i = 0; i < 5; i++)
         add(1'b1, 8'b0000_1111, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      // 5: en=0 with arbitrary codes, then the held reference still accepts a +1 step
      add(1'b0, 8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      add(1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      add(1'b0, 8'hFF, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      add(1'b0, 8'h3C, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      add(1'b1, code_of(5), 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      // illegal pulse cleared by en=0; next legal code after it is a fresh reference
      add(1'b1, 8'h5A, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      add(1'b0, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      add(1'b1, code_of(7), 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);

      rst  = 1'b0;
      en   = 1'b0;
      q_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].en, vecs[i].q);
         chk_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].vld, vecs[i].ill,
                 vecs[i].serr, vecs[i].wrp, vecs[i].lk, vecs[i].cyc);
      end

      // 6: relock from phase 7, then 256 locked rotations; cycle_cnt rolls over
      apply(1'b1, code_of(8));
      apply(1'b1, code_of(9));
      apply(1'b1, code_of(10));
      chk("relock.locked", 32'(locked), 32'd1);
      k = 10;
      wraps = 0;
      seen_wraps = 0;
      exp_cyc = 8'd3;
      for (int n = 0; n < 256 * 16; n++) begin
         k = (k + 1) % 16;
         apply(1'b1, code_of(k));
         if (wrap === 1'b1) seen_wraps++;
         if (k == 0) begin
            wraps++;
            exp_cyc = exp_cyc + 8'd1;
            chk("rot.wrap", 32'(wrap), 32'd1);
            chk("rot.cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
            if (exp_cyc == 8'd0) chk("rot.rollover", 32'(cycle_cnt), 32'd0);
         end else begin
            chk("rot.nowrap", 32'(wrap), 32'd0);
         end
         chk("rot.phase", 32'(phase), 32'(k));
      end
      chk("rot.wrap_count", 32'(seen_wraps), 32'(wraps));
      chk("rot.final_cyc", 32'(cycle_cnt), 32'd3);

      // asynchronous reset between edges
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      apply(1'b1, code_of(11));
      chk_all("post_rst", 11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
